// File: rtl/sal_cmd_sched.sv
// Per-channel DRAM command scheduler: fixed class priority COL > ACT > PRE > REF, round-robin per class.
// Grants are combinational in the request cycle; the command bus is registered one cycle later; requests are held until granted.
module sal_cmd_sched #(
    parameter int NUM_BANKS = 4,
    parameter int RA_W      = 16,
    parameter int CA_W      = 10,
    parameter int TW        = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_BANKS-1:0]          act_req_i,
    input  logic [NUM_BANKS-1:0]          rd_req_i,
    input  logic [NUM_BANKS-1:0]          wr_req_i,
    input  logic [NUM_BANKS-1:0]          pre_req_i,
    input  logic [NUM_BANKS-1:0]          ref_req_i,
    input  logic [NUM_BANKS*RA_W-1:0]     ra_i,
    input  logic [NUM_BANKS*CA_W-1:0]     ca_i,
    input  logic [TW-1:0]                 t_rrd_m1,
    input  logic [TW-1:0]                 t_ccd_m1,
    input  logic [TW-1:0]                 t_wtr_m1,
    input  logic [TW-1:0]                 t_rtw_m1,
    output logic [NUM_BANKS-1:0]          act_gnt_o,
    output logic [NUM_BANKS-1:0]          rd_gnt_o,
    output logic [NUM_BANKS-1:0]          wr_gnt_o,
    output logic [NUM_BANKS-1:0]          pre_gnt_o,
    output logic [NUM_BANKS-1:0]          ref_gnt_o,
    output logic                          cmd_valid_o,
    output logic [2:0]                    cmd_o,
    output logic [$clog2(NUM_BANKS)-1:0]  cmd_bk_o,
    output logic [RA_W-1:0]               cmd_ra_o,
    output logic [CA_W-1:0]               cmd_ca_o
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam logic [BW-1:0] BK_ONE = 1;
    localparam logic [TW-1:0] T_ONE  = 1;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ACT = 3'd1,
        OP_RD  = 3'd2,
        OP_WR  = 3'd3,
        OP_PRE = 3'd4,
        OP_REF = 3'd5
    } op_e;

    logic [TW-1:0] r_rrd_cnt, r_ccd_cnt, r_wtr_cnt, r_rtw_cnt;
    logic [BW-1:0] r_rr_col, r_rr_act, r_rr_pre, r_rr_ref;
    logic          r_cmd_vld;
    op_e           r_cmd;
    logic [BW-1:0] r_cmd_bk;
    logic [RA_W-1:0] r_cmd_ra;
    logic [CA_W-1:0] r_cmd_ca;

    logic [RA_W-1:0] w_ra [NUM_BANKS];
    logic [CA_W-1:0] w_ca [NUM_BANKS];
    logic [NUM_BANKS-1:0] w_col_elig, w_act_elig;
    logic [BW:0]   w_col_pick, w_act_pick, w_pre_pick, w_ref_pick;
    logic          w_rd_ok, w_wr_ok;
    op_e           w_op;
    logic [BW-1:0] w_bk;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_unpack
        assign w_ra[b] = ra_i[b*RA_W +: RA_W];
        assign w_ca[b] = ca_i[b*CA_W +: CA_W];
    end

    // Returns {found, bank}: first set bit at or after ptr, wrapping.
    function automatic logic [BW:0] rr_pick(input logic [NUM_BANKS-1:0] vec, input logic [BW-1:0] ptr);
        logic [BW:0]   res;
        logic [BW-1:0] idx;
        res = '0;
        for (int i = NUM_BANKS-1; i >= 0; i--) begin
            idx = ptr + BW'(i);
            if (vec[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] cnt);
        return (cnt == '0) ? cnt : cnt - T_ONE;
    endfunction

    assign w_rd_ok    = (r_ccd_cnt == '0) && (r_wtr_cnt == '0);
    assign w_wr_ok    = (r_ccd_cnt == '0) && (r_rtw_cnt == '0);
    // A bank raising RD and WR together is treated as RD only.
    assign w_col_elig = (rd_req_i & {NUM_BANKS{w_rd_ok}}) |
                        (wr_req_i & ~rd_req_i & {NUM_BANKS{w_wr_ok}});
    assign w_act_elig = act_req_i & {NUM_BANKS{r_rrd_cnt == '0}};
    assign w_col_pick = rr_pick(w_col_elig, r_rr_col);
    assign w_act_pick = rr_pick(w_act_elig, r_rr_act);
    assign w_pre_pick = rr_pick(pre_req_i, r_rr_pre);
    assign w_ref_pick = rr_pick(ref_req_i, r_rr_ref);

    always_comb begin
        act_gnt_o = '0;
        rd_gnt_o  = '0;
        wr_gnt_o  = '0;
        pre_gnt_o = '0;
        ref_gnt_o = '0;
        w_op      = OP_NOP;
        w_bk      = '0;
        if (w_col_pick[BW]) begin
            w_bk = w_col_pick[BW-1:0];
            if (rd_req_i[w_bk]) begin
                rd_gnt_o[w_bk] = 1'b1;
                w_op           = OP_RD;
            end else begin
                wr_gnt_o[w_bk] = 1'b1;
                w_op           = OP_WR;
            end
        end else if (w_act_pick[BW]) begin
            w_bk            = w_act_pick[BW-1:0];
            act_gnt_o[w_bk] = 1'b1;
            w_op            = OP_ACT;
        end else if (w_pre_pick[BW]) begin
            w_bk            = w_pre_pick[BW-1:0];
            pre_gnt_o[w_bk] = 1'b1;
            w_op            = OP_PRE;
        end else if (w_ref_pick[BW]) begin
            w_bk            = w_ref_pick[BW-1:0];
            ref_gnt_o[w_bk] = 1'b1;
            w_op            = OP_REF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rrd_cnt <= '0;
            r_ccd_cnt <= '0;
            r_wtr_cnt <= '0;
            r_rtw_cnt <= '0;
            r_rr_col  <= '0;
            r_rr_act  <= '0;
            r_rr_pre  <= '0;
            r_rr_ref  <= '0;
            r_cmd_vld <= 1'b0;
            r_cmd     <= OP_NOP;
            r_cmd_bk  <= '0;
            r_cmd_ra  <= '0;
            r_cmd_ca  <= '0;
        end else begin
            r_rrd_cnt <= (w_op == OP_ACT) ? t_rrd_m1 : dec_sat(r_rrd_cnt);
            r_ccd_cnt <= (w_op == OP_RD || w_op == OP_WR) ? t_ccd_m1 : dec_sat(r_ccd_cnt);
            r_rtw_cnt <= (w_op == OP_RD) ? t_rtw_m1 : dec_sat(r_rtw_cnt);
            r_wtr_cnt <= (w_op == OP_WR) ? t_wtr_m1 : dec_sat(r_wtr_cnt);
            if (w_op == OP_RD || w_op == OP_WR) r_rr_col <= w_bk + BK_ONE;
            if (w_op == OP_ACT) r_rr_act <= w_bk + BK_ONE;
            if (w_op == OP_PRE) r_rr_pre <= w_bk + BK_ONE;
            if (w_op == OP_REF) r_rr_ref <= w_bk + BK_ONE;
            r_cmd_vld <= (w_op != OP_NOP);
            r_cmd     <= w_op;
            r_cmd_bk  <= w_bk;
            r_cmd_ra  <= (w_op == OP_ACT) ? w_ra[w_bk] : '0;
            r_cmd_ca  <= (w_op == OP_RD || w_op == OP_WR) ? w_ca[w_bk] : '0;
        end
    end

    assign cmd_valid_o = r_cmd_vld;
    assign cmd_o       = r_cmd;
    assign cmd_bk_o    = r_cmd_bk;
    assign cmd_ra_o    = r_cmd_ra;
    assign cmd_ca_o    = r_cmd_ca;

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n) (rd_req_i & wr_req_i) == '0);
    a_gnt_onehot: assert property (@(posedge clk)
        $onehot0({act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o}));

endmodule

// File: doc/sal_cmd_sched.md
# sal_cmd_sched

Per-channel DRAM command scheduler: the granting end of the bank-controller request/grant interface. Each cycle it collects ACT/RD/WR/PRE/REF requests from all bank controllers. It enforces inter-bank timing (tRRD, tCCD, tWTR, tRTW) and returns at most one same-cycle grant. The granted command is registered onto the channel command bus toward the PHY.

## Interface
- NUM_BANKS, 4: bank controllers served; power of two, at least 2.
- RA_W, 16: row address width.
- CA_W, 10: column address width.
- TW, 6: width of every timing input and counter.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i  in  NUM_BANKS each  per-bank requests, bit b = bank b.
- ra_i  in  NUM_BANKS*RA_W  per-bank row address; bank b at [b*RA_W +: RA_W].
- ca_i  in  NUM_BANKS*CA_W  per-bank column address, same packing.
- t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1  in  TW each  timing value minus 1; quasi-static.
- act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o  out  NUM_BANKS each  combinational grants. Across all five vectors, at most one bit is set.
- cmd_valid_o  out  1  registered; a command is on the bus.
- cmd_o  out  3  registered opcode: NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5.
- cmd_bk_o  out  log2(NUM_BANKS)  registered bank index.
- cmd_ra_o  out  RA_W  registered row; valid for ACT, otherwise 0.
- cmd_ca_o  out  CA_W  registered column; valid for RD/WR, otherwise 0.

## Operation
- Requesters hold a request until granted. A grant is combinational in the request cycle and is a one-cycle pulse. The bank controller acts on it in that same cycle.
- Eligibility per bank b:
  - RD: rd_req_i[b], ccd_cnt==0 and wtr_cnt==0.
  - WR: wr_req_i[b], ccd_cnt==0 and rtw_cnt==0.
  - ACT: act_req_i[b] and rrd_cnt==0.
  - PRE and REF: always eligible when requested.
- Class priority is fixed: COL (RD or WR) > ACT > PRE > REF. Only the highest class with an eligible bank is granted.
- Within a class, banks are round-robin. Each class has its own pointer rr_col, rr_act, rr_pre, rr_ref.
  - The search starts at the pointer and wraps modulo NUM_BANKS.
  - After a grant to bank b in class X, rr_X becomes (b+1) mod NUM_BANKS. The other pointers are unchanged.
- If one bank asserts RD and WR in the same cycle (illegal), RD wins. A simulation assertion flags it.
- Timing counters (TW bits each) work as follows:
  - On an ACT grant, rrd_cnt loads t_rrd_m1.
  - On an RD grant, ccd_cnt loads t_ccd_m1 and rtw_cnt loads t_rtw_m1.
  - On a WR grant, ccd_cnt loads t_ccd_m1 and wtr_cnt loads t_wtr_m1.
  - Otherwise each counter decrements while nonzero and saturates at 0.
- Command register: on any grant, the next cycle shows cmd_valid_o=1, the opcode, the bank index and the relevant address. The unused address field is 0. With no grant, the next cycle shows cmd_valid_o=0, cmd_o=NOP and all other fields 0.

## Timing
- Reset (asynchronous assert, synchronous deassert handled externally) sets:
  - cmd_valid_o=0, cmd_o=0, cmd_bk_o=0, cmd_ra_o=0, cmd_ca_o=0.
  - All counters 0 and all rr pointers 0.
  - Grants are therefore immediately possible after reset.
- Reset mid-operation clears counters, pointers and the command register immediately. Grants remain a pure function of the inputs and the cleared state.
- Grant-to-bus latency is 1 cycle. Throughput is 1 command per cycle.
- Spacing from a grant at cycle n:
  - The next command of the same constrained type is grantable at cycle n+1+t_x_m1.
  - t_x_m1=0 allows back-to-back commands.
  - A counter reloads when a new grant coincides with a nonzero count. Reload takes precedence over decrement.
- A blocked higher class never stalls a lower class. Example: RD blocked by wtr while ACT is eligible means ACT is granted.
- Grant vectors are one-hot or zero in every cycle, including during reset (inputs permitting).

## Test plan
- Reset, then rd_req_i=4'b0001 with ca_i bank0=0x3A. Required: rd_gnt_o=0001 in the same cycle; the next cycle shows cmd_valid_o=1, cmd_o=2, cmd_bk_o=0, cmd_ca_o=0x3A.
- t_rrd_m1=3; act_req_i=4'b1111 held. Required: ACT grants at cycles 0, 4, 8, 12 to banks 0, 1, 2, 3 in order; no ACT grant in between.
- t_wtr_m1=5; WR bank1 granted at cycle 0, then rd_req_i bank2 asserted. Required: RD granted no earlier than cycle 6; pre_req_i bank3 asserted at cycle 2 is granted at cycle 2.
- act_req_i bank0, rd_req_i bank1 and pre_req_i bank2 all asserted, all timing met. Required: RD bank1 first, then ACT bank0, then PRE bank2 on consecutive cycles.
- ref_req_i=4'b1111 held with no other traffic. Required: ref_gnt_o is 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- rst_n asserted while ccd_cnt=4. Required: all outputs 0 immediately; after release, rd_req_i is granted in the first cycle.
